// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through data cache, one word per line, true-LRU
// replacement, req/ack miss path to memory, flush and saturating hit/miss counters.
module set_assoc_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_WIDTH  = 3,
  parameter int WAYS       = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  req_ready_o,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_hit_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  input  logic                  flush_i,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);
  localparam int SETS  = 1 << SET_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - SET_WIDTH - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, RESP} state_t;
  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;
  typedef struct packed {
    logic                  hit;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  state_t                     state, state_n;
  logic [SETS-1:0][WAYS-1:0]  valid;
  ages_t [SETS-1:0]           age;
  logic [TAG_W-1:0]           tags [SETS][WAYS];
  logic [DATA_WIDTH-1:0]      data [SETS][WAYS];
  rsp_t                       rsp;
  logic                       flush_pend;

  logic [SET_WIDTH-1:0] lk_set, fl_set;
  logic [TAG_W-1:0]     lk_tag, fl_tag;
  logic                 lk_hit;
  logic [WAY_W-1:0]     lk_way, victim;
  logic                 accept, ack, fill;
  logic                 unused;

  assign lk_set = req_addr_i[SET_WIDTH+1:2];
  assign lk_tag = req_addr_i[ADDR_WIDTH-1:SET_WIDTH+2];
  // The outstanding miss address doubles as the fill index/tag.
  assign fl_set = mem_addr_o[SET_WIDTH+1:2];
  assign fl_tag = mem_addr_o[ADDR_WIDTH-1:SET_WIDTH+2];
  assign unused = ^{req_addr_i[1:0], mem_addr_o[1:0]};

  assign req_ready_o  = (state == IDLE) && !flush_i && !flush_pend;
  assign accept       = req_valid_i && req_ready_o;
  assign ack          = mem_req_o && mem_ack_i;
  assign fill         = (state == RD_MISS) && ack;
  assign resp_valid_o = (state == RESP);
  assign resp_hit_o   = resp_valid_o && rsp.hit;
  assign resp_rdata_o = resp_valid_o ? rsp.rdata : '0;

  // Touched way becomes MRU; ways younger than it age by one.
  function automatic ages_t lru_touch(ages_t a, logic [WAY_W-1:0] w);
    ages_t n;
    for (int i = 0; i < WAYS; i++) begin
      if (i == int'(w))    n[i] = '0;
      else if (a[i] < a[w]) n[i] = a[i] + 1'b1;
      else                 n[i] = a[i];
    end
    return n;
  endfunction

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (valid[lk_set][w] && tags[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
  end

  // Lowest invalid way wins over the LRU way.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[fl_set][w] == WAY_W'(WAYS-1)) victim = WAY_W'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid[fl_set][w]) victim = WAY_W'(w);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:            if (accept) state_n = req_we_i ? WR_MEM : (lk_hit ? RESP : RD_MISS);
      RD_MISS, WR_MEM: if (ack)    state_n = RESP;
      RESP:            state_n = IDLE;
      default:         state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      rsp          <= '0;
      flush_pend   <= 1'b0;
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (state != IDLE && flush_i) flush_pend <= 1'b1;
      if (state == IDLE && (flush_i || flush_pend)) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end
      if (accept) begin
        rsp.hit   <= lk_hit;
        rsp.rdata <= (lk_hit && !req_we_i) ? data[lk_set][lk_way] : '0;
        if (lk_hit) age[lk_set] <= lru_touch(age[lk_set], lk_way);
        if (req_we_i || !lk_hit) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= req_we_i;
          mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_o <= req_we_i ? req_wdata_i : '0;
        end
      end
      if (ack) begin
        mem_req_o <= 1'b0;
        mem_we_o  <= 1'b0;
      end
      if (fill) begin
        valid[fl_set][victim] <= 1'b1;
        age[fl_set]           <= lru_touch(age[fl_set], victim);
        rsp.rdata             <= mem_rdata_i;
      end
      if (state == RESP) begin
        if (rsp.hit) begin
          if (~&hit_count_o) hit_count_o <= hit_count_o + 1'b1;
        end else begin
          if (~&miss_count_o) miss_count_o <= miss_count_o + 1'b1;
        end
      end
    end
  end

  // Payload arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (accept && req_we_i && lk_hit) data[lk_set][lk_way] <= req_wdata_i;
    if (fill) begin
      tags[fl_set][victim] <= fl_tag;
      data[fl_set][victim] <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: way/recency-list cache model, memory responder,
// per-cycle response/counter comparison and hand-pinned expectations.
module tb_set_assoc_cache;
  localparam int SETS = 8;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0, flush = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        req_ready, resp_valid, resp_hit, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt;
  logic        unused_ready, unused_valid, unused_hit, unused_req, unused_we;
  logic [31:0] unused_rdata, unused_addr, unused_wdata;
  logic [1:0]  hit_cnt_c, miss_cnt_c;

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_ready_o(req_ready), .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata), .resp_hit_o(resp_hit), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .flush_i(flush), .hit_count_o(hit_cnt), .miss_count_o(miss_cnt));

  set_assoc_cache #(.CNT_WIDTH(2)) dut_c (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_ready_o(unused_ready), .resp_valid_o(unused_valid),
    .resp_rdata_o(unused_rdata), .resp_hit_o(unused_hit), .mem_req_o(unused_req),
    .mem_we_o(unused_we), .mem_addr_o(unused_addr), .mem_wdata_o(unused_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .flush_i(flush),
    .hit_count_o(hit_cnt_c), .miss_count_o(miss_cnt_c));

  int checks = 0, fails = 0;
  bit zw = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-way valid/address/data plus a recency list of way numbers (MRU first).
  bit          mv   [SETS][WAYS];
  logic [31:0] maddr[SETS][WAYS];
  logic [31:0] mdat [SETS][WAYS];
  int          ord  [SETS][$];
  logic [31:0] mem  [logic [31:0]];

  typedef struct { bit hit; logic [31:0] rdata; } exp_t;
  exp_t eq[$];
  int hits_m = 0, miss_m = 0;

  function automatic logic [31:0] memval(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic int sat3(int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      ord[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0;
        ord[s].push_back(w);
      end
    end
  endtask

  task automatic touch(input int s, input int w);
    int idx = 0;
    for (int i = 0; i < ord[s].size(); i++) if (ord[s][i] == w) idx = i;
    ord[s].delete(idx);
    ord[s].push_front(w);
  endtask

  // Response and counter comparison, every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hits_m = 0; miss_m = 0; eq.delete();
      chk("rst_resp_valid", {31'b0, resp_valid}, 0);
      chk("rst_mem_req", {31'b0, mem_req}, 0);
    end else begin
      chk("hit_count", hit_cnt, hits_m);
      chk("miss_count", miss_cnt, miss_m);
      chk("hit_count_sat", {30'b0, hit_cnt_c}, sat3(hits_m));
      chk("miss_count_sat", {30'b0, miss_cnt_c}, sat3(miss_m));
      if (resp_valid) begin
        if (eq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_resp: got resp_valid 1 expected 0 at %0t", $time);
        end else begin
          e = eq.pop_front();
          chk("resp_hit", {31'b0, resp_hit}, {31'b0, e.hit});
          chk("resp_rdata", resp_rdata, e.rdata);
          if (e.hit) hits_m++; else miss_m++;
        end
      end
    end
  end

  // lat: cycles of mem_req before ack (<0: reset mid-miss). hand_hit<0: no literal pin.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input int hand_hit, input logic [31:0] hand_rd);
    int s, w, v, n;
    bit h, r;
    exp_t e;
    s = int'(a[4:2]); h = 0; w = 0;
    for (int i = 0; i < WAYS; i++) if (mv[s][i] && maddr[s][i] == a) begin h = 1; w = i; end
    @(posedge clk) #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; mem_rdata = memval(a);
    n = 0;
    do begin
      @(negedge clk) r = req_ready;
      @(posedge clk) #1;
      n++;
    end while (!r && n < 20);
    req_valid = 0;
    if (!r) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 at %0t", $time);
      return;
    end
    e.hit = h;
    e.rdata = we ? 32'h0 : (h ? mdat[s][w] : memval(a));
    eq.push_back(e);
    if (h) begin
      touch(s, w);
      if (we) mdat[s][w] = wd;
    end else if (!we) begin
      v = -1;
      for (int i = WAYS-1; i >= 0; i--) if (!mv[s][i]) v = i;
      if (v < 0) v = ord[s][ord[s].size()-1];
      mv[s][v] = 1; maddr[s][v] = a; mdat[s][v] = memval(a);
      touch(s, v);
    end
    if (h && !we) begin
      @(negedge clk);
      chk("hit_latency", {31'b0, resp_valid}, 1);
      chk("hit_no_mem_req", {31'b0, mem_req}, 0);
    end else begin
      @(negedge clk);
      chk("mem_req_rise", {31'b0, mem_req}, 1);
      chk("mem_we", {31'b0, mem_we}, {31'b0, we});
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, wd);
      if (lat < 0) begin
        @(posedge clk) #1;
        rst = 1;
        #1;
        chk("rst_async_mem_req", {31'b0, mem_req}, 0);
        chk("rst_no_resp", {31'b0, resp_valid}, 0);
        @(posedge clk) #1;
        rst = 0;
        model_reset();
        return;
      end
      for (int k = 1; k <= lat; k++) begin
        if (k == lat && !zw) mem_ack = 1;
        if (k > 1) begin
          @(negedge clk);
          chk("mem_req_hold", {31'b0, mem_req}, 1);
          chk("mem_addr_hold", mem_addr, a);
        end
        @(posedge clk) #1;
        if (!zw) mem_ack = 0;
      end
      @(negedge clk);
      chk("miss_latency", {31'b0, resp_valid}, 1);
      chk("mem_req_drop", {31'b0, mem_req}, 0);
      if (we) mem[a] = wd;
    end
    if (hand_hit >= 0) begin
      chk("hand_hit", {31'b0, resp_hit}, hand_hit);
      chk("hand_rdata", resp_rdata, hand_rd);
    end
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst = 1;
    repeat (2) @(posedge clk) #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 0);
    chk("reset_mem_req", {31'b0, mem_req}, 0);
    chk("reset_hit_count", hit_cnt, 0);
  endtask

  initial begin
    model_reset();
    mem[32'h40] = 32'hDEADBEEF;
    do_reset();

    // Miss then hit on the same line
    access(0, 32'h40, 0, 3, 0, 32'hDEADBEEF);
    access(0, 32'h40, 0, 3, 1, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_hits", hit_cnt, 1);
    chk("t1_misses", miss_cnt, 1);

    // LRU eviction within set 0
    do_reset();
    access(0, 32'h00, 0, 2, 0, 32'h5A5A0000);
    access(0, 32'h20, 0, 1, 0, 32'h5A5A0020);
    access(0, 32'h00, 0, 1, 1, 32'h5A5A0000);
    access(0, 32'h40, 0, 2, 0, 32'hDEADBEEF);
    access(0, 32'h00, 0, 1, 1, 32'h5A5A0000);
    access(0, 32'h20, 0, 1, 0, 32'h5A5A0020);

    // Write-through stores: hit updates the line, miss leaves the cache alone
    access(0, 32'h40, 0, 1, 0, 32'hDEADBEEF);
    access(1, 32'h40, 32'h12345678, 2, 1, 0);
    access(0, 32'h40, 0, 1, 1, 32'h12345678);
    access(1, 32'h80, 32'hCAFEF00D, 1, 0, 0);
    access(0, 32'h80, 0, 2, 0, 32'hCAFEF00D);

    // Flush invalidates every set
    do_reset();
    for (int i = 1; i <= 4; i++) access(0, 32'(i*4), 0, 1, 0, 32'h5A5A0000 | 32'(i*4));
    access(0, 32'h04, 0, 1, 1, 32'h5A5A0004);
    @(posedge clk) #1;
    flush = 1;
    @(negedge clk);
    chk("flush_ready_low", {31'b0, req_ready}, 0);
    @(posedge clk) #1;
    flush = 0;
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
    for (int i = 1; i <= 4; i++) access(0, 32'(i*4), 0, 2, 0, 32'h5A5A0000 | 32'(i*4));

    // Reset abandons an outstanding miss
    do_reset();
    access(0, 32'h100, 0, -1, -1, 0);
    @(negedge clk);
    chk("abort_miss_count", miss_cnt, 0);
    access(0, 32'h100, 0, 1, 0, 32'h5A5A0100);

    // Zero-wait memory and counter saturation
    do_reset();
    @(posedge clk) #1;
    zw = 1; mem_ack = 1;
    access(0, 32'h200, 0, 1, 0, 32'h5A5A0200);
    repeat (5) access(0, 32'h200, 0, 1, 1, 32'h5A5A0200);
    @(negedge clk);
    chk("sat_hit_count", {30'b0, hit_cnt_c}, 3);
    chk("full_hit_count", hit_cnt, 5);
    chk("full_miss_count", miss_cnt, 1);
    zw = 0; mem_ack = 0;

    @(negedge clk);
    chk("pending_responses", eq.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
